// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Moore FSM that sequences a multicycle MIPS datapath (PC, unified
//   instruction/data memory, IR, register file, ALU). The FSM decodes the IR,
//   drives the per-state enables and mux selects, stalls on the memory
//   handshake, and parks in HALT when it sees an illegal opcode or funct.
//
// Ports
//   clock          in   rising-edge clock
//   resetN         in   synchronous active-low reset (forces FETCH)
//   instr[31:0]    in   IR contents; opcode = [31:26], funct = [5:0]
//   zero           in   ALU zero flag, used only for the branch decision
//   memReady       in   memory completes the pending access this cycle
//   pcEn           out  PC write enable
//   iorD           out  memory address select: 0 = PC, 1 = ALUOut
//   memReq         out  memory access request, held until memReady
//   memWrite       out  memory write strobe (qualified by memReq)
//   irWrite        out  load IR from memory read data
//   regDst         out  write-register select: 0 = rt, 1 = rd
//   memToReg       out  write-data select: 0 = ALUOut, 1 = memory data reg
//   regWriteEnable out  register file write enable
//   aluSrcA        out  0 = PC, 1 = RD1
//   aluSrcB[1:0]   out  00 = RD2, 01 = 4, 10 = SignImm, 11 = SignImm << 2
//   aluControl[2:0] out 010 add, 110 sub, 000 and, 001 or, 111 slt
//   pcSrc[1:0]     out  00 = ALUResult, 01 = ALUOut, 10 = jump target
//   state[3:0]     out  current state code (debug visibility)
//   halted         out  high while in HALT
// ---------------------------------------------------------------------------
module multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_ADDI  = 6'h08,
  parameter logic [5:0] OP_J     = 6'h02
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        memReady,
  output logic        pcEn,
  output logic        iorD,
  output logic        memReq,
  output logic        memWrite,
  output logic        irWrite,
  output logic        regDst,
  output logic        memToReg,
  output logic        regWriteEnable,
  output logic        aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic [2:0]  aluControl,
  output logic [1:0]  pcSrc,
  output logic [3:0]  state,
  output logic        halted
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11,
    HALT   = 4'd15
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     cur;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_instr_bits;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  // Register/immediate fields are consumed by the datapath, not by control.
  assign unused_instr_bits = ^instr[25:6];
  assign state = cur;

  // Supported R-type functions; anything else is treated as illegal.
  function automatic logic funct_legal(input logic [5:0] f);
    case (f)
      6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: funct_legal = 1'b1;
      default:                           funct_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'h22:   funct_alu = ALU_SUB;
      6'h24:   funct_alu = ALU_AND;
      6'h25:   funct_alu = ALU_OR;
      6'h2A:   funct_alu = ALU_SLT;
      default: funct_alu = ALU_ADD;
    endcase
  endfunction

  // State register; reset wins over every state, including a pending stall.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      cur <= FETCH;
    end else begin
      case (cur)
        FETCH:  if (memReady) cur <= DECODE;
        DECODE: begin
          if (opcode == OP_LW || opcode == OP_SW) cur <= MEMADR;
          else if (opcode == OP_RTYPE)            cur <= EXEC;
          else if (opcode == OP_BEQ)              cur <= BRANCH;
          else if (opcode == OP_ADDI)             cur <= ADDIEX;
          else if (opcode == OP_J)                cur <= JUMP;
          else                                    cur <= HALT;
        end
        // Only LW/SW reach MEMADR, so anything that is not LW is a store.
        MEMADR: cur <= (opcode == OP_LW) ? MEMRD : MEMWR;
        MEMRD:  if (memReady) cur <= MEMWB;
        MEMWB:  cur <= FETCH;
        MEMWR:  if (memReady) cur <= FETCH;
        EXEC:   cur <= funct_legal(funct) ? ALUWB : HALT;
        ALUWB:  cur <= FETCH;
        BRANCH: cur <= FETCH;
        ADDIEX: cur <= ADDIWB;
        ADDIWB: cur <= FETCH;
        JUMP:   cur <= FETCH;
        HALT:   cur <= HALT;
        default: cur <= HALT;
      endcase
    end
  end

  // Output decode of the registered state. The FETCH write enables follow
  // memReady so IR and PC update exactly on the completing cycle, and the
  // BRANCH PC enable follows the ALU compare.
  always_comb begin
    pcEn           = 1'b0;
    iorD           = 1'b0;
    memReq         = 1'b0;
    memWrite       = 1'b0;
    irWrite        = 1'b0;
    regDst         = 1'b0;
    memToReg       = 1'b0;
    regWriteEnable = 1'b0;
    aluSrcA        = 1'b0;
    aluSrcB        = 2'b00;
    aluControl     = ALU_ADD;
    pcSrc          = 2'b00;
    halted         = 1'b0;
    case (cur)
      FETCH: begin
        memReq  = 1'b1;
        aluSrcB = 2'b01;
        irWrite = memReady;
        pcEn    = memReady;
      end
      DECODE: aluSrcB = 2'b11;
      MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      MEMRD: begin
        memReq = 1'b1;
        iorD   = 1'b1;
      end
      MEMWB: begin
        regWriteEnable = 1'b1;
        memToReg       = 1'b1;
      end
      MEMWR: begin
        memReq   = 1'b1;
        memWrite = 1'b1;
        iorD     = 1'b1;
      end
      EXEC: begin
        aluSrcA    = 1'b1;
        aluControl = funct_alu(funct);
      end
      ALUWB: begin
        regWriteEnable = 1'b1;
        regDst         = 1'b1;
      end
      BRANCH: begin
        aluSrcA    = 1'b1;
        aluControl = ALU_SUB;
        pcSrc      = 2'b01;
        pcEn       = zero;
      end
      ADDIEX: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      ADDIWB: regWriteEnable = 1'b1;
      JUMP: begin
        pcSrc = 2'b10;
        pcEn  = 1'b1;
      end
      HALT:    halted = 1'b1;
      default: halted = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//   Directed instruction sequences for the multicycle control FSM. The
//   stimulus process queues the hand-derived state code and output bundle
//   expected for each cycle; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  logic        clock;
  logic        resetN;
  logic [31:0] instr;
  logic        zero;
  logic        memReady;
  logic        pcEn, iorD, memReq, memWrite, irWrite, regDst, memToReg;
  logic        regWriteEnable, aluSrcA, halted;
  logic [1:0]  aluSrcB, pcSrc;
  logic [2:0]  aluControl;
  logic [3:0]  state;

  multicycle_control dut (
    .clock(clock), .resetN(resetN), .instr(instr), .zero(zero),
    .memReady(memReady), .pcEn(pcEn), .iorD(iorD), .memReq(memReq),
    .memWrite(memWrite), .irWrite(irWrite), .regDst(regDst),
    .memToReg(memToReg), .regWriteEnable(regWriteEnable), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .aluControl(aluControl), .pcSrc(pcSrc),
    .state(state), .halted(halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Bundle order:
  // pcEn iorD memReq memWrite irWrite regDst memToReg regWE aluSrcA
  // aluSrcB[1:0] aluControl[2:0] pcSrc[1:0] halted
  logic [16:0] obs;
  assign obs = {pcEn, iorD, memReq, memWrite, irWrite, regDst, memToReg,
                regWriteEnable, aluSrcA, aluSrcB, aluControl, pcSrc, halted};

  localparam logic [16:0] O_FETCH_R  = 17'b1_0_1_0_1_0_0_0_0_01_010_00_0;
  localparam logic [16:0] O_FETCH_NR = 17'b0_0_1_0_0_0_0_0_0_01_010_00_0;
  localparam logic [16:0] O_DECODE   = 17'b0_0_0_0_0_0_0_0_0_11_010_00_0;
  localparam logic [16:0] O_MEMADR   = 17'b0_0_0_0_0_0_0_0_1_10_010_00_0;
  localparam logic [16:0] O_MEMRD    = 17'b0_1_1_0_0_0_0_0_0_00_010_00_0;
  localparam logic [16:0] O_MEMWB    = 17'b0_0_0_0_0_0_1_1_0_00_010_00_0;
  localparam logic [16:0] O_MEMWR    = 17'b0_1_1_1_0_0_0_0_0_00_010_00_0;
  localparam logic [16:0] O_EXEC_ADD = 17'b0_0_0_0_0_0_0_0_1_00_010_00_0;
  localparam logic [16:0] O_EXEC_SUB = 17'b0_0_0_0_0_0_0_0_1_00_110_00_0;
  localparam logic [16:0] O_EXEC_SLT = 17'b0_0_0_0_0_0_0_0_1_00_111_00_0;
  localparam logic [16:0] O_ALUWB    = 17'b0_0_0_0_0_1_0_1_0_00_010_00_0;
  localparam logic [16:0] O_BR_Z     = 17'b1_0_0_0_0_0_0_0_1_00_110_01_0;
  localparam logic [16:0] O_BR_NZ    = 17'b0_0_0_0_0_0_0_0_1_00_110_01_0;
  localparam logic [16:0] O_ADDIEX   = 17'b0_0_0_0_0_0_0_0_1_10_010_00_0;
  localparam logic [16:0] O_ADDIWB   = 17'b0_0_0_0_0_0_0_1_0_00_010_00_0;
  localparam logic [16:0] O_JUMP     = 17'b1_0_0_0_0_0_0_0_0_00_010_10_0;
  localparam logic [16:0] O_HALT     = 17'b0_0_0_0_0_0_0_0_0_00_010_00_1;

  typedef struct packed {
    logic [3:0]  st;
    logic [16:0] o;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  // One cycle of stimulus: drive inputs just after the edge and queue what the
  // DUT must show for the rest of this cycle.
  task automatic step(input logic rn, input logic mr, input logic z,
                      input logic [3:0] st, input logic [16:0] o);
    exp_t e;
    @(posedge clock);
    #1;
    resetN   = rn;
    memReady = mr;
    zero     = z;
    e.st = st;
    e.o  = o;
    q.push_back(e);
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (state !== e.st) begin
        errors++;
        $display("FAIL state: got %0d expected %0d (t=%0t)", state, e.st, $time);
      end
      checks++;
      if (obs !== e.o) begin
        errors++;
        $display("FAIL outputs in state %0d: got %b expected %b (t=%0t)",
                 e.st, obs, e.o, $time);
      end
    end
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
    end
  end

  initial begin
    resetN   = 1'b0;
    memReady = 1'b0;
    zero     = 1'b0;
    instr    = 32'h0000_0000;
    repeat (3) @(posedge clock);

    // add $3,$1,$2
    instr = 32'h0022_1820;
    step(1, 1, 0, 4'd0, O_FETCH_R);
    step(1, 0, 0, 4'd1, O_DECODE);
    step(1, 0, 0, 4'd6, O_EXEC_ADD);
    step(1, 0, 0, 4'd7, O_ALUWB);

    // lw with three stall cycles in FETCH and in MEMRD (11 cycles)
    step(1, 0, 0, 4'd0, O_FETCH_NR);
    instr = 32'h8C22_0004;
    step(1, 0, 0, 4'd0, O_FETCH_NR);
    step(1, 0, 0, 4'd0, O_FETCH_NR);
    step(1, 1, 0, 4'd0, O_FETCH_R);
    step(1, 0, 0, 4'd1, O_DECODE);
    step(1, 0, 0, 4'd2, O_MEMADR);
    step(1, 0, 0, 4'd3, O_MEMRD);
    step(1, 0, 0, 4'd3, O_MEMRD);
    step(1, 0, 0, 4'd3, O_MEMRD);
    step(1, 1, 0, 4'd3, O_MEMRD);
    step(1, 1, 0, 4'd4, O_MEMWB);

    // sw
    instr = 32'hAC22_0004;
    step(1, 1, 0, 4'd0, O_FETCH_R);
    step(1, 1, 0, 4'd1, O_DECODE);
    step(1, 1, 0, 4'd2, O_MEMADR);
    step(1, 1, 0, 4'd5, O_MEMWR);

    // beq taken, then not taken
    instr = 32'h1022_0003;
    step(1, 1, 0, 4'd0, O_FETCH_R);
    step(1, 1, 0, 4'd1, O_DECODE);
    step(1, 1, 1, 4'd8, O_BR_Z);
    step(1, 1, 0, 4'd0, O_FETCH_R);
    step(1, 1, 0, 4'd1, O_DECODE);
    step(1, 1, 0, 4'd8, O_BR_NZ);

    // addi
    instr = 32'h2022_0005;
    step(1, 1, 0, 4'd0, O_FETCH_R);
    step(1, 0, 0, 4'd1, O_DECODE);
    step(1, 0, 0, 4'd9, O_ADDIEX);
    step(1, 0, 0, 4'd10, O_ADDIWB);

    // j
    instr = 32'h0800_0010;
    step(1, 1, 0, 4'd0, O_FETCH_R);
    step(1, 1, 0, 4'd1, O_DECODE);
    step(1, 1, 0, 4'd11, O_JUMP);

    // sub and slt exercise the funct decode
    instr = 32'h0022_1822;
    step(1, 1, 0, 4'd0, O_FETCH_R);
    step(1, 1, 0, 4'd1, O_DECODE);
    step(1, 1, 0, 4'd6, O_EXEC_SUB);
    step(1, 1, 0, 4'd7, O_ALUWB);
    instr = 32'h0022_182A;
    step(1, 1, 0, 4'd0, O_FETCH_R);
    step(1, 1, 0, 4'd1, O_DECODE);
    step(1, 1, 0, 4'd6, O_EXEC_SLT);
    step(1, 1, 0, 4'd7, O_ALUWB);

    // illegal opcode: halt, sticky, reset recovers
    instr = 32'hFC00_0000;
    step(1, 1, 0, 4'd0, O_FETCH_R);
    step(1, 1, 0, 4'd1, O_DECODE);
    step(1, 1, 0, 4'd15, O_HALT);
    step(1, 1, 1, 4'd15, O_HALT);
    step(0, 1, 0, 4'd15, O_HALT);
    step(1, 0, 0, 4'd0, O_FETCH_NR);

    // illegal funct: EXEC goes to HALT with no writeback
    instr = 32'h0022_183F;
    step(1, 1, 0, 4'd0, O_FETCH_R);
    step(1, 1, 0, 4'd1, O_DECODE);
    step(1, 1, 0, 4'd6, O_EXEC_ADD);
    step(1, 1, 0, 4'd15, O_HALT);
    step(0, 0, 0, 4'd15, O_HALT);
    step(1, 0, 0, 4'd0, O_FETCH_NR);

    // reset held two cycles starting from EXEC
    instr = 32'h0022_1820;
    step(1, 1, 0, 4'd0, O_FETCH_R);
    step(1, 1, 0, 4'd1, O_DECODE);
    step(0, 1, 0, 4'd6, O_EXEC_ADD);
    step(0, 1, 0, 4'd0, O_FETCH_R);
    step(1, 0, 0, 4'd0, O_FETCH_NR);
    step(1, 1, 0, 4'd0, O_FETCH_R);
    step(1, 1, 0, 4'd1, O_DECODE);

    @(posedge clock);
    @(negedge clock);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
